writeback_queue: RTL and testbench

//   Writeback stage directly upstream of registerfile. Accepts up to two results per cycle

---
 rtl/aap_defs.sv | 13 +
 rtl/wb_fifo_2w2r.sv | 62 ++++++
 rtl/writeback_queue.sv | 83 ++++++++
 tb/tb_writeback_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/aap_defs.sv
// rtl/aap_defs.sv - shared writeback widths and queue entry layout
package aap_defs;
    localparam int AAP_DATA_W = 8;
    localparam int AAP_ADDR_W = 2;
    localparam int AAP_NREGS  = 1 << AAP_ADDR_W;
    localparam int AAP_DEPTH  = 4;

    typedef struct packed {
        logic                  valid;
        logic [AAP_ADDR_W-1:0] addr;
        logic [AAP_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo_2w2r.sv
// rtl/wb_fifo_2w2r.sv - two-push/two-pop circular buffer with occupancy count
module wb_fifo_2w2r #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             push_n,
    input  logic [WIDTH-1:0]       push_data0,
    input  logic [WIDTH-1:0]       push_data1,
    input  logic [1:0]             pop_n,
    output logic [WIDTH-1:0]       head_data0,
    output logic [WIDTH-1:0]       head_data1,
    output logic [CW-1:0]          count,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH*WIDTH-1:0] entry_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail, head_p1, tail_p1;
    logic [DEPTH-1:0] valid_q, valid_d;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // Popped and pushed slots never coincide: the caller only pushes into free slots.
    always_comb begin
        valid_d = valid_q;
        if (pop_n != 2'd0)  valid_d[head]    = 1'b0;
        if (pop_n == 2'd2)  valid_d[head_p1] = 1'b0;
        if (push_n != 2'd0) valid_d[tail]    = 1'b1;
        if (push_n == 2'd2) valid_d[tail_p1] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            head    <= head + PW'(pop_n);
            tail    <= tail + PW'(push_n);
            count   <= count + CW'(push_n) - CW'(pop_n);
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_n != 2'd0) mem[tail]    <= push_data0;
        if (push_n == 2'd2) mem[tail_p1] <= push_data1;
    end

    assign head_data0  = mem[head];
    assign head_data1  = mem[head_p1];
    assign entry_valid = valid_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign entry_data[i*WIDTH +: WIDTH] = mem[i];
    end
endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback queue feeding the register file write ports
module writeback_queue
    import aap_defs::*;
#(
    parameter int DATA_W = AAP_DATA_W,
    parameter int ADDR_W = AAP_ADDR_W,
    parameter int DEPTH  = AAP_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     in_ready,
    input  logic                     wb_hold,
    output logic [ADDR_W-1:0]        wr1,
    output logic [DATA_W-1:0]        wr1_data,
    output logic                     wr1_enable,
    output logic [ADDR_W-1:0]        wr2,
    output logic [DATA_W-1:0]        wr2_data,
    output logic                     wr2_enable,
    output logic [(1<<ADDR_W)-1:0]   pend_mask,
    output logic                     empty
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               a_ent, b_ent, push0, h0, h1;
    logic [1:0]           push_n, pop_n;
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     entry_valid;
    logic [DEPTH*EW-1:0]  entry_data;

    assign a_ent = '{valid: 1'b1, addr: a_addr, data: a_data};
    assign b_ent = '{valid: 1'b1, addr: b_addr, data: b_data};

    // Two free slots are always demanded, so a full pair can never overflow.
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_n   = in_ready ? ({1'b0, a_valid} + {1'b0, b_valid}) : 2'd0;
    assign push0    = a_valid ? a_ent : b_ent;

    assign wr1_enable = !wb_hold && (count != '0) && h0.valid;
    assign wr2_enable = !wb_hold && (count >= CW'(2)) && h1.valid;
    assign pop_n      = {1'b0, wr1_enable} + {1'b0, wr2_enable};

    assign wr1      = wr1_enable ? h0.addr : '0;
    assign wr1_data = wr1_enable ? h0.data : '0;
    assign wr2      = wr2_enable ? h1.addr : '0;
    assign wr2_data = wr2_enable ? h1.data : '0;
    assign empty    = (count == '0);

    wb_fifo_2w2r #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_n      (push_n),
        .push_data0  (push0),
        .push_data1  (b_ent),
        .pop_n       (pop_n),
        .head_data0  (h0),
        .head_data1  (h1),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_data  (entry_data)
    );

    always_comb begin
        entry_t e;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = entry_data[i*EW +: EW];
            if (entry_valid[i] && e.valid) pend_mask[e.addr] = 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed bench with queue-level reference model
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_valid, b_valid, wb_hold;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       in_ready, wr1_enable, wr2_enable, empty;
    logic [1:0] wr1, wr2;
    logic [7:0] wr1_data, wr2_data;
    logic [3:0] pend_mask;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } ent_t;
    ent_t       q[$];
    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    writeback_queue dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .in_ready(in_ready), .wb_hold(wb_hold),
        .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
        .wr2(wr2), .wr2_data(wr2_data), .wr2_enable(wr2_enable),
        .pend_mask(pend_mask), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: outputs follow from the ordered list of queued results.
    always @(negedge clock) begin
        if (!reset_n) begin
            check("rst_wr1_enable", wr1_enable, 0);
            check("rst_wr2_enable", wr2_enable, 0);
            check("rst_pend_mask", pend_mask, 0);
            check("rst_empty", empty, 1);
            check("rst_in_ready", in_ready, 1);
            q.delete();
        end else begin
            int n, ndeq;
            logic [3:0] m;
            logic e1, e2, rdy;
            n   = q.size();
            e1  = !wb_hold && n >= 1;
            e2  = !wb_hold && n >= 2;
            rdy = (DEPTH - n) >= 2;
            m   = 4'b0;
            foreach (q[i]) m[q[i].addr] = 1'b1;
            check("m_wr1_enable", wr1_enable, e1);
            check("m_wr2_enable", wr2_enable, e2);
            check("m_wr1", {wr1, wr1_data}, e1 ? {q[0].addr, q[0].data} : 10'h0);
            check("m_wr2", {wr2, wr2_data}, e2 ? {q[1].addr, q[1].data} : 10'h0);
            check("m_pend_mask", pend_mask, m);
            check("m_empty", empty, n == 0);
            check("m_in_ready", in_ready, rdy);
            ndeq = int'(e1) + int'(e2);
            for (int k = 0; k < ndeq; k++) begin
                ent_t e;
                e = q.pop_front();
                rf[e.addr] = e.data;
            end
            if (rdy) begin
                if (a_valid) q.push_back('{a_addr, a_data});
                if (b_valid) q.push_back('{b_addr, b_data});
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic setin(input logic av, input logic [1:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [1:0] ba, input logic [7:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    initial begin
        reset_n = 1'b0;
        wb_hold = 1'b0;
        setin(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_empty", empty, 1);
        check("reset_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // 1: lane A alone
        setin(1, 2'd1, 8'h11, 0, 0, 0);
        step;
        setin(0, 0, 0, 0, 0, 0);
        check("t1_wr1", wr1, 1);
        check("t1_wr1_data", wr1_data, 8'h11);
        check("t1_wr1_enable", wr1_enable, 1);
        check("t1_wr2_enable", wr2_enable, 0);
        step;

        // 2: same-address pair, younger wins
        setin(1, 2'd2, 8'hAA, 1, 2'd2, 8'hBB);
        step;
        setin(0, 0, 0, 0, 0, 0);
        check("t2_wr1_data", wr1_data, 8'hAA);
        check("t2_wr2_data", wr2_data, 8'hBB);
        check("t2_enables", {wr1_enable, wr2_enable}, 2'b11);
        step;
        check("t2_rf_r2", rf[2], 8'hBB);

        // 3: hold fills the queue, third pair refused
        wb_hold = 1'b1;
        setin(1, 2'd0, 8'h01, 1, 2'd1, 8'h02);
        step;
        setin(1, 2'd2, 8'h03, 1, 2'd3, 8'h04);
        step;
        setin(1, 2'd0, 8'h05, 1, 2'd1, 8'h06);
        check("t3_in_ready", in_ready, 0);
        check("t3_pend_mask", pend_mask, 4'hF);
        step;
        check("t3_still_full", in_ready, 0);
        setin(0, 0, 0, 0, 0, 0);
        wb_hold = 1'b0;
        #1;
        check("t3_drain1", {wr1_data, wr2_data}, 16'h0102);
        step;
        check("t3_drain2", {wr1_data, wr2_data}, 16'h0304);
        step;
        check("t3_empty", empty, 1);

        // 4: lane B alone drains on port 1
        setin(0, 0, 0, 1, 2'd3, 8'h33);
        step;
        setin(0, 0, 0, 0, 0, 0);
        check("t4_wr1", {wr1, wr1_data}, {2'd3, 8'h33});
        check("t4_wr2_enable", wr2_enable, 0);
        step;

        // 5: sustained two-in/two-out across pointer wrap
        for (int i = 0; i < 10; i++) begin
            setin(1, 2'(i), 8'(8'h40 + 2*i), 1, 2'(i + 1), 8'(8'h41 + 2*i));
            step;
            check("t5_in_ready", in_ready, 1);
            check("t5_pair", {wr1_data, wr2_data}, {8'(8'h40 + 2*i), 8'(8'h41 + 2*i)});
        end
        setin(0, 0, 0, 0, 0, 0);
        step;

        // 6: reset with three entries queued
        wb_hold = 1'b1;
        setin(1, 2'd1, 8'h61, 1, 2'd2, 8'h62);
        step;
        setin(1, 2'd3, 8'h63, 0, 0, 0);
        step;
        setin(0, 0, 0, 0, 0, 0);
        check("t6_pend_before", pend_mask, 4'b1110);
        #3 reset_n = 1'b0;
        #1;
        check("t6_enables", {wr1_enable, wr2_enable}, 2'b00);
        check("t6_pend_mask", pend_mask, 0);
        check("t6_empty", empty, 1);
        step;
        step;
        reset_n = 1'b1;
        wb_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("t6_no_write", {wr1_enable, wr2_enable}, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
